credit_rr_arbiter: RTL and testbench
====================================

CREDIT_RR_ARBITER -- requirements
Module: credit_rr_arbiter

Interface
REQ-001 SHALL have parameter D_WIDTH, default 6, the data width per requester and downstream.
REQ-002 SHALL have parameter CREDIT_WIDTH, default 3, the credit counter width.
REQ-003 SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port req_data, input, 4*D_WIDTH bits: requester i data in bits [i*D_WIDTH +: D_WIDTH].
REQ-006 SHALL have port req_valid, input, 4 bits: per-requester valid.
REQ-007 SHALL have port req_ready, output, 4 bits: per-requester ready (grant), combinational from state and req_valid.
REQ-008 SHALL have port down_data, output, D_WIDTH bits: registered granted data.
REQ-009 SHALL have port down_valid, output, 1 bit: registered beat valid.
REQ-010 SHALL have port down_src, output, 2 bits: registered index of the source requester.
REQ-011 SHALL have port down_credit, input, 1 bit: one credit returned per asserted cycle.
REQ-012 SHALL have port credit_initval, input, CREDIT_WIDTH bits: counter load value at reset.
REQ-013 SHALL have port credit_ovf, output, 1 bit: sticky credit overflow error flag.

Function
REQ-014 SHALL transfer from requester i in a cycle iff req_valid[i] & req_ready[i]; at most one req_ready bit is high per cycle.
REQ-015 SHALL assert no req_ready while the credit counter is zero.
REQ-016 SHALL pick the grantee round-robin: first valid requester at or after pointer rr_ptr, searching i = rr_ptr, rr_ptr+1, ... mod 4.
REQ-017 SHALL set rr_ptr to (grantee+1) mod 4 after each transfer; rr_ptr unchanged in cycles without transfer.
REQ-018 SHALL present a transferred beat on down_data/down_src with down_valid high exactly one cycle later (latency 1); otherwise down_valid low next cycle.
REQ-019 SHALL update the counter per cycle: transfer only -> minus 1; down_credit only -> plus 1; both or neither -> unchanged.
REQ-020 SHALL ignore a down_credit that would wrap the counter past all-ones (counter held) and set credit_ovf, which stays high until reset.
REQ-021 SHALL never underflow the counter (guaranteed by REQ-015).
REQ-022 SHALL make a credit returned in cycle N usable for a grant in cycle N+1, not N.
REQ-023 SHALL give down_data no reset requirement; its value is don't-care while down_valid is low.

Reset
REQ-024 SHALL on rst load counter with credit_initval, rr_ptr with 0, down_valid 0, down_src 0, credit_ovf 0, lock state IDLE.
REQ-025 SHALL, with rst high, drive req_ready to 0; a beat in the downstream register is discarded, and credits in flight are not recovered.
REQ-026 SHALL allow credit_initval = 0: no grants until credits are returned.

Configuration
REQ-027 SHALL support macro CREDARB_LOCK_EN for packet lock.
REQ-028 With CREDARB_LOCK_EN defined, SHALL add input req_last (4 bits) and a two-state FSM: IDLE and LOCKED.
REQ-029 In IDLE, a transfer with req_last[grantee]=0 SHALL move the FSM to LOCKED(grantee).
REQ-030 In LOCKED(g), only requester g SHALL be eligible; the FSM returns to IDLE after a transfer from g with req_last[g]=1.
REQ-031 In LOCKED(g), credit exhaustion SHALL stall g without releasing the lock.
REQ-032 In LOCKED(g), rr_ptr SHALL update only on the final (last) beat.
REQ-033 Without CREDARB_LOCK_EN, SHALL omit the req_last port and the FSM, with arbitration per beat.

Verification
REQ-034 SHALL cover: credit_initval=3, all req_valid high, no credits returned -> grants to 0,1,2, then req_ready all 0, counter 0.
REQ-035 SHALL cover: counter=2, transfer and down_credit in the same cycle -> counter stays 2, down_valid high next cycle.
REQ-036 SHALL cover: req_valid=4'b1010, ample credit -> grants alternate 1,3,1,3; down_src matches one cycle later.
REQ-037 SHALL cover: CREDIT_WIDTH=3, counter=7, down_credit=1 -> counter stays 7, credit_ovf=1 until rst.
REQ-038 SHALL cover: counter=0, down_credit pulse in cycle N -> first req_ready in cycle N+1.
REQ-039 SHALL cover, with CREDARB_LOCK_EN: requester 2 sends a 3-beat packet while requester 0 is valid -> beats 2,2,2, then 0.

Source files
------------

// File: rtl/credit_rr_arbiter.sv
// credit_rr_arbiter: four-way round-robin arbiter feeding one downstream port
// that is flow-controlled by credits. A grant consumes one credit. Each cycle
// with down_credit high returns one credit. The granted beat is registered
// toward the downstream side with one cycle of latency.
// Optional feature: define CREDARB_LOCK_EN to add req_last and packet lock.
// With packet lock, a multi-beat packet keeps ownership of the output until
// its final beat has been sent.
module credit_rr_arbiter #(
    parameter int D_WIDTH      = 6,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*D_WIDTH-1:0]    req_data,
    input  logic [3:0]              req_valid,
    output logic [3:0]              req_ready,
    output logic [D_WIDTH-1:0]      down_data,
    output logic                    down_valid,
    output logic [1:0]              down_src,
    input  logic                    down_credit,
    input  logic [CREDIT_WIDTH-1:0] credit_initval,
`ifdef CREDARB_LOCK_EN
    input  logic [3:0]              req_last,
`endif
    output logic                    credit_ovf
);

    localparam logic [CREDIT_WIDTH-1:0] CNT_ONE = CREDIT_WIDTH'(1);

    logic [CREDIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]              rr_ptr_q, rr_ptr_d;
    logic                    ovf_q, ovf_d;
    logic                    dv_q, dv_d;
    logic [1:0]              src_q, src_d;
    logic [D_WIDTH-1:0]      data_q, data_d;

    logic                    cand_found;
    logic [1:0]              cand_idx;
    logic [1:0]              scan_idx;
    logic                    grant_valid;
    logic [1:0]              grant_idx;
    logic [D_WIDTH-1:0]      grant_data;
    logic                    xfer;

`ifdef CREDARB_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_state_e;
    lock_state_e lock_state_q;
    logic [1:0]  lock_owner_q;
`endif

    // Round-robin scan: the first valid requester at or after rr_ptr wins
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = 2'd0;
        scan_idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (!cand_found && req_valid[scan_idx]) begin
                cand_found = 1'b1;
                cand_idx   = scan_idx;
            end
        end
    end

    // Grant: a packet lock overrides the scan; no grant in reset or without credit
    always_comb begin
        grant_valid = cand_found;
        grant_idx   = cand_idx;
`ifdef CREDARB_LOCK_EN
        if (lock_state_q == LOCKED) begin
            grant_valid = req_valid[lock_owner_q];
            grant_idx   = lock_owner_q;
        end
`endif
        req_ready = 4'b0000;
        if (!rst && (cnt_q != '0) && grant_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = |req_ready;

    // Select the data lane of the granted requester
    always_comb begin
        grant_data = req_data[D_WIDTH-1:0];
        for (int i = 0; i < 4; i++) begin
            if (grant_idx == 2'(i)) begin
                grant_data = req_data[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

    // Next state: credit accounting, rotation pointer, and the downstream beat
    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        rr_ptr_d = rr_ptr_q;
        dv_d     = xfer;
        src_d    = src_q;
        data_d   = data_q;

        // A return that arrives in the same cycle as a grant cancels the grant's cost.
        // A return with the counter already all-ones is dropped and recorded as overflow.
        if (xfer && !down_credit) begin
            cnt_d = cnt_q - CNT_ONE;
        end else if (!xfer && down_credit) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        if (xfer) begin
            src_d  = grant_idx;
            data_d = grant_data;
`ifdef CREDARB_LOCK_EN
            // While a packet holds the lock, rotation waits for its final beat
            if ((lock_state_q == IDLE) || req_last[grant_idx]) begin
                rr_ptr_d = grant_idx + 2'd1;
            end
`else
            rr_ptr_d = grant_idx + 2'd1;
`endif
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= credit_initval;
            rr_ptr_q <= 2'd0;
            ovf_q    <= 1'b0;
            dv_q     <= 1'b0;
            src_q    <= 2'd0;
        end else begin
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            ovf_q    <= ovf_d;
            dv_q     <= dv_d;
            src_q    <= src_d;
        end
    end

    // Downstream data register; its content only matters while down_valid is high
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

`ifdef CREDARB_LOCK_EN
    // Packet lock FSM: a non-final beat from IDLE locks to its source until that source's final beat
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state_q <= IDLE;
            lock_owner_q <= 2'd0;
        end else if (xfer) begin
            case (lock_state_q)
                IDLE: begin
                    if (!req_last[grant_idx]) begin
                        lock_state_q <= LOCKED;
                        lock_owner_q <= grant_idx;
                    end
                end
                LOCKED: begin
                    if (req_last[grant_idx]) begin
                        lock_state_q <= IDLE;
                    end
                end
                default: lock_state_q <= IDLE;
            endcase
        end
    end
`endif

    assign down_data  = data_q;
    assign down_valid = dv_q;
    assign down_src   = src_q;
    assign credit_ovf = ovf_q;

endmodule

// File: tb/tb_credit_rr_arbiter.sv
// Testbench for credit_rr_arbiter. It uses directed scenarios plus randomized
// traffic. Expected values come from a behavioural model that tracks credits
// as an integer count. The model chooses grantees by a modular search from the
// rotation pointer.
// The CREDARB_LOCK_EN scenarios are included when the macro is defined.
module tb_credit_rr_arbiter;

    localparam int DW   = 6;
    localparam int CW   = 3;
    localparam int CMAX = (1 << CW) - 1;
`ifdef CREDARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_valid;
    logic [3:0]      req_ready;
    logic [DW-1:0]   down_data;
    logic            down_valid;
    logic [1:0]      down_src;
    logic            down_credit;
    logic [CW-1:0]   credit_initval;
    logic            credit_ovf;
`ifdef CREDARB_LOCK_EN
    logic [3:0]      req_last;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int            m_cnt;
    int            m_ptr;
    int            m_owner;
    bit            m_locked;
    bit            m_ovf;
    bit            e_dv;
    int            e_src;
    logic [DW-1:0] e_data;

    credit_rr_arbiter #(.D_WIDTH(DW), .CREDIT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .down_data      (down_data),
        .down_valid     (down_valid),
        .down_src       (down_src),
        .down_credit    (down_credit),
        .credit_initval (credit_initval),
`ifdef CREDARB_LOCK_EN
        .req_last       (req_last),
`endif
        .credit_ovf     (credit_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Grantee the rules allow this cycle, or -1 when nobody may transfer
    function automatic int model_pick(input logic [3:0] v);
        int i;
        if (m_cnt == 0) return -1;
        if (m_locked) return v[m_owner] ? m_owner : -1;
        for (int k = 0; k < 4; k++) begin
            i = (m_ptr + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic do_reset(input logic [CW-1:0] init);
        rst            = 1'b1;
        credit_initval = init;
        req_valid      = 4'hF;
        down_credit    = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_down_valid", 32'(down_valid), 32'd0);
        chk("rst_down_src", 32'(down_src), 32'd0);
        chk("rst_ovf", 32'(credit_ovf), 32'd0);
        rst      = 1'b0;
        m_cnt    = int'(init);
        m_ptr    = 0;
        m_owner  = 0;
        m_locked = 1'b0;
        m_ovf    = 1'b0;
        e_dv     = 1'b0;
        e_src    = 0;
        e_data   = '0;
    endtask

    // One clock: drive inputs at the falling edge, check, then advance the model
    task automatic cycle(input logic [3:0] v, input logic cr, input logic [3:0] last);
        int         g;
        logic [3:0] er;
        req_valid   = v;
        down_credit = cr;
`ifdef CREDARB_LOCK_EN
        req_last    = last;
`endif
        for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = DW'($urandom);
        #1;
        g  = model_pick(v);
        er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("down_valid", 32'(down_valid), 32'(e_dv));
        if (e_dv) begin
            chk("down_src", 32'(down_src), e_src);
            chk("down_data", 32'(down_data), 32'(e_data));
        end
        chk("credit_ovf", 32'(credit_ovf), 32'(m_ovf));
        @(posedge clk);
        e_dv = (g >= 0);
        if (g >= 0) begin
            e_src  = g;
            e_data = req_data[g*DW +: DW];
        end
        if ((g >= 0) && !cr) begin
            m_cnt--;
        end else if ((g < 0) && cr) begin
            if (m_cnt == CMAX) m_ovf = 1'b1;
            else m_cnt++;
        end
        if (g >= 0) begin
            if (LOCK_EN && m_locked) begin
                if (last[g]) begin
                    m_locked = 1'b0;
                    m_ptr    = (g + 1) % 4;
                end
            end else begin
                m_ptr = (g + 1) % 4;
                if (LOCK_EN && !last[g]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        req_valid      = 4'h0;
        req_data       = '0;
        down_credit    = 1'b0;
        credit_initval = '0;
`ifdef CREDARB_LOCK_EN
        req_last       = 4'hF;
`endif
        @(negedge clk);

        // Three credits, all requesters valid, no returns: grants go to 0, 1, 2, then stop.
        // A return arriving while the counter is zero enables a grant only in the next cycle.
        do_reset(3'd3);
        for (int i = 0; i < 4; i++) cycle(4'hF, 1'b0, 4'hF);
        cycle(4'hF, 1'b1, 4'hF);
        cycle(4'hF, 1'b0, 4'hF);
        cycle(4'hF, 1'b0, 4'hF);

        // A grant and a return in the same cycle leave the count at 2
        do_reset(3'd2);
        cycle(4'hF, 1'b1, 4'hF);
        for (int i = 0; i < 3; i++) cycle(4'hF, 1'b0, 4'hF);

        // With requesters 1 and 3 valid, grants alternate between them
        do_reset(3'd7);
        for (int i = 0; i < 6; i++) cycle(4'b1010, 1'b1, 4'hF);

        // A return with the counter full sets the sticky overflow flag
        do_reset(3'd7);
        cycle(4'h0, 1'b1, 4'hF);
        for (int i = 0; i < 9; i++) cycle(4'hF, 1'b0, 4'hF);

        // Credit initial value 0: nothing is granted until a credit comes back
        do_reset(3'd0);
        cycle(4'hF, 1'b0, 4'hF);
        cycle(4'h0, 1'b1, 4'hF);
        cycle(4'hF, 1'b0, 4'hF);

`ifdef CREDARB_LOCK_EN
        // Requester 2 sends a three-beat packet while requester 0 waits: 2, 2, 2, then 0
        do_reset(3'd7);
        cycle(4'b0100, 1'b0, 4'b0000);
        cycle(4'b0101, 1'b0, 4'b0000);
        cycle(4'b0101, 1'b0, 4'b0100);
        cycle(4'b0101, 1'b0, 4'b0001);
        cycle(4'b0101, 1'b0, 4'b0001);

        // Running out of credits stalls the locked packet but keeps the lock
        do_reset(3'd1);
        cycle(4'b0010, 1'b0, 4'b0000);
        cycle(4'b1111, 1'b0, 4'b0000);
        cycle(4'b1111, 1'b1, 4'b0000);
        cycle(4'b1111, 1'b0, 4'b0010);
        cycle(4'b1111, 1'b1, 4'b1111);
        cycle(4'b1111, 1'b0, 4'b1111);
`endif

        // Random traffic with periodic resets to random initial credit values
        for (int r = 0; r < 20; r++) begin
            do_reset(CW'($urandom));
            for (int c = 0; c < 40; c++) begin
                cycle(4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
